// File: rtl/adat_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adat_frame_reader
// Brief    : Reads completed ADAT frames from the bit-serial channel buffer and
//            streams each channel slot as a parallel sample (valid/ready).
//            Define ADAT_FRAME_READER_OVERRUN_CNT_EN to add overrun_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module adat_frame_reader #(
    parameter int CIRC_BUF_BITS = 3,
    parameter int CHANNELS      = 8,
    parameter int SAMPLE_WIDTH  = 24
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     has_sync_i,
    input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
    input  logic [3:0]               user_bits_i,
    output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
    input  logic                     ram_read_data_i,
    output logic [SAMPLE_WIDTH-1:0]  sample_o,
    output logic [2:0]               channel_o,
    output logic [3:0]               user_bits_o,
    output logic                     first_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o,
    output logic                     overrun_o
`ifdef ADAT_FRAME_READER_OVERRUN_CNT_EN
    ,
    output logic [15:0]              overrun_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CIRC_BUF_BITS-1:0] prev_idx;
    logic [CIRC_BUF_BITS-1:0] frame_idx;
    logic [CIRC_BUF_BITS-1:0] pend_idx;
    logic [CIRC_BUF_BITS-1:0] start_idx;
    logic                     pending;
    logic [2:0]               channel;
    logic [2:0]               channel_inc;
    logic [5:0]               bit_cnt;
    logic                     frame_event;
    logic                     start;
    logic                     last_bit;
    logic                     last_chan;
    logic                     overrun_set;
    logic [SAMPLE_WIDTH-1:0]  sample_shift;

    assign frame_event = has_sync_i && (last_good_frame_idx_i != prev_idx);
    assign start       = (state == IDLE) && (frame_event || (pending && has_sync_i));
    assign start_idx   = pending ? pend_idx : last_good_frame_idx_i;
    assign last_bit    = (bit_cnt == 6'(SAMPLE_WIDTH));
    assign last_chan   = (channel == 3'(CHANNELS - 1));
    assign channel_inc = channel + 3'd1;
    assign overrun_set = frame_event && (state != IDLE) && pending;
    assign channel_o   = channel;

    generate
        if (SAMPLE_WIDTH == 1) begin : g_shift_single
            assign sample_shift = ram_read_data_i;
        end else begin : g_shift_multi
            assign sample_shift = {sample_o[SAMPLE_WIDTH-2:0], ram_read_data_i};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        first_o   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy_o = 1'b1;
                if (last_bit) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                first_o = (channel == 3'd0);
                if (ready_i) begin
                    state_nxt = last_chan ? IDLE : LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_idx        <= '0;
            frame_idx       <= '0;
            pend_idx        <= '0;
            pending         <= 1'b0;
            channel         <= 3'd0;
            bit_cnt         <= 6'd0;
            sample_o        <= '0;
            user_bits_o     <= 4'd0;
            ram_read_addr_o <= '0;
            overrun_o       <= 1'b0;
        end else begin
            prev_idx  <= last_good_frame_idx_i;
            overrun_o <= overrun_set;

            // A coincident event in IDLE takes the slot freed by the starting frame.
            if (!has_sync_i) begin
                pending <= 1'b0;
            end else if (frame_event) begin
                pend_idx <= last_good_frame_idx_i;
                if (state != IDLE) begin
                    pending <= 1'b1;
                end
            end else if (state == IDLE) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        frame_idx       <= start_idx;
                        user_bits_o     <= user_bits_i;
                        channel         <= 3'd0;
                        bit_cnt         <= 6'd0;
                        ram_read_addr_o <= {start_idx, 3'd0, 5'd0};
                    end
                end
                LOAD: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    // Read data trails the address by one cycle.
                    if (bit_cnt != 6'd0) begin
                        sample_o <= sample_shift;
                    end
                    if (bit_cnt < 6'(SAMPLE_WIDTH - 1)) begin
                        ram_read_addr_o[4:0] <= ram_read_addr_o[4:0] + 5'd1;
                    end
                end
                OUT: begin
                    if (ready_i && !last_chan) begin
                        channel         <= channel_inc;
                        bit_cnt         <= 6'd0;
                        ram_read_addr_o <= {frame_idx, channel_inc, 5'd0};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADAT_FRAME_READER_OVERRUN_CNT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overrun_count_o <= 16'd0;
        end else if (overrun_set && (overrun_count_o != 16'hFFFF)) begin
            overrun_count_o <= overrun_count_o + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
